// File: rtl/r200dmem.sv
// r200 data-memory responder: valid/ready load/store target with WAIT_CYC wait states.
// Optional R200_DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module r200dmem #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W+1:0]   addr_q;
    logic                wr_q;
    logic [2:0]          func3_q;
    logic [31:0]         wdata_q;
    logic                rsp_valid_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic [31:0]         mem_q [DEPTH];

    logic                accept;
    logic                commit;
    logic                use_req;
    logic [ADDR_W+1:0]   c_addr;
    logic                c_wr;
    logic [2:0]          c_f3;
    logic [31:0]         c_wdata;
    logic [ADDR_W-1:0]   idx;
    logic [1:0]          lane;
    logic [31:0]         rword;
    logic [7:0]          rbyte;
    logic [15:0]         rhalf;
    logic                legal;
    logic                mis;
    logic                err_d;
    logic [31:0]         ld_data;
    logic [31:0]         rdata_d;
    logic [3:0]          be;
    logic [31:0]         wword;
    logic                wr_en;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign req_ready = rst_n && (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // With zero wait states the access commits on the accept edge, straight from the request bus.
    assign use_req = (state_q == S_IDLE);
    assign c_addr  = use_req ? req_addr[ADDR_W+1:0] : addr_q;
    assign c_wr    = use_req ? req_wr    : wr_q;
    assign c_f3    = use_req ? req_func3 : func3_q;
    assign c_wdata = use_req ? req_wdata : wdata_q;

    assign commit = rst_n && ((accept && (WAIT_CYC == 0)) ||
                              (state_q == S_WAIT && cnt_q == 4'd1));

    assign idx   = c_addr[ADDR_W+1:2];
    assign lane  = c_addr[1:0];
    assign rword = mem_q[idx];
    assign rbyte = rword[8*lane +: 8];
    assign rhalf = c_addr[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        legal   = 1'b0;
        mis     = 1'b0;
        ld_data = 32'd0;
        be      = 4'd0;
        wword   = 32'd0;
        if (!c_wr) begin
            case (c_f3)
                3'b000: begin legal = 1'b1; ld_data = {{24{rbyte[7]}}, rbyte}; end
                3'b001: begin legal = 1'b1; mis = c_addr[0]; ld_data = {{16{rhalf[15]}}, rhalf}; end
                3'b010: begin legal = 1'b1; mis = |c_addr[1:0]; ld_data = rword; end
                3'b100: begin legal = 1'b1; ld_data = {24'd0, rbyte}; end
                3'b101: begin legal = 1'b1; mis = c_addr[0]; ld_data = {16'd0, rhalf}; end
                default: ;
            endcase
        end else begin
            case (c_f3)
                3'b000: begin legal = 1'b1; be = 4'b0001 << lane; wword = {4{c_wdata[7:0]}}; end
                3'b001: begin
                    legal = 1'b1;
                    mis   = c_addr[0];
                    be    = c_addr[1] ? 4'b1100 : 4'b0011;
                    wword = {2{c_wdata[15:0]}};
                end
                3'b010: begin legal = 1'b1; mis = |c_addr[1:0]; be = 4'b1111; wword = c_wdata; end
                default: ;
            endcase
        end
    end

`ifdef R200_DMEM_MISALIGN_TRAP_EN
    assign err_d = !legal || mis;
`else
    logic unused_mis;
    assign unused_mis = mis;
    assign err_d = !legal;
`endif

    assign rdata_d = (c_wr || err_d) ? 32'd0 : ld_data;
    assign wr_en   = commit && c_wr && !err_d;

    // Array contents survive reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && be[i]) mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            func3_q     <= 3'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
            case (state_q)
                S_IDLE: if (accept) begin
                    addr_q  <= req_addr[ADDR_W+1:0];
                    wr_q    <= req_wr;
                    func3_q <= req_func3;
                    wdata_q <= req_wdata;
                    cnt_q   <= 4'(WAIT_CYC);
                    if (WAIT_CYC == 0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                S_RESP: if (rsp_ready) begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_r200dmem.sv
// Directed bench for r200dmem: instance 0 uses WAIT_CYC=1, instance 1 uses WAIT_CYC=3.
module tb_r200dmem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        req_wr    [2];
    logic [2:0]  req_func3 [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    r200dmem #(.ADDR_W(10), .WAIT_CYC(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_wr(req_wr[0]), .req_func3(req_func3[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    r200dmem #(.ADDR_W(10), .WAIT_CYC(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_wr(req_wr[1]), .req_func3(req_func3[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // Issue one request, wait for the response, take it. lat counts cycles from accept to rsp_valid.
    task automatic xact(input int d, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1; req_wr[d] = wr; req_func3[d] = f3;
        req_addr[d] = a; req_wdata[d] = wd;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata[d];
        er = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== 35'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d got rdy=%b vld=%b err=%b rd=%h exp all zero",
                         d, req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_release req_ready got %b exp 1", req_ready[0]);
        end
    endtask

    task automatic test_roundtrip();
        logic [31:0] rd; logic er; int lat;
        xact(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if ({er, rd, lat} !== {1'b0, 32'h0, 32'd2}) begin
            errors++;
            $display("FAIL sw_rsp got err=%b rd=%h lat=%0d exp err=0 rd=0 lat=2", er, rd, lat);
        end
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd, lat} !== {1'b0, 32'hDEADBEEF, 32'd2}) begin
            errors++;
            $display("FAIL lw_roundtrip got err=%b rd=%h lat=%0d exp err=0 rd=deadbeef lat=2", er, rd, lat);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat;
        xact(0, 1'b1, 3'b000, 32'h13, 32'h00000080, rd, er, lat);
        xact(0, 1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'hFFFFFF80}) begin
            errors++; $display("FAIL lb_13 got err=%b rd=%h exp 0 ffffff80", er, rd);
        end
        xact(0, 1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h00000080}) begin
            errors++; $display("FAIL lbu_13 got err=%b rd=%h exp 0 00000080", er, rd);
        end
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h80ADBEEF}) begin
            errors++; $display("FAIL lw_after_sb got err=%b rd=%h exp 0 80adbeef", er, rd);
        end
        xact(0, 1'b0, 3'b000, 32'h11, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'hFFFFFFBE}) begin
            errors++; $display("FAIL lb_11 got err=%b rd=%h exp 0 ffffffbe", er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n;
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b0; req_func3[0] = 3'b010;
        req_addr[0] = 32'h10; req_wdata[0] = 32'h0;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        // A competing store stays on the bus for the whole stall and must not be taken.
        req_wr[0] = 1'b1; req_wdata[0] = 32'h11111111;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]} !== {3'b100, 32'h80ADBEEF}) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got vld=%b rdy=%b err=%b rd=%h exp 1 0 0 80adbeef",
                         i, rsp_valid[0], req_ready[0], rsp_err[0], rsp_rdata[0]);
            end
        end
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b0;
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++; $display("FAIL bp_take_cycle req_ready got %b exp 0", req_ready[0]);
        end
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        checks++;
        if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b exp 0 1", rsp_valid[0], req_ready[0]);
        end
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h80ADBEEF}) begin
            errors++; $display("FAIL bp_no_write got err=%b rd=%h exp 0 80adbeef", er, rd);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat;
        xact(0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL st_f3_011 got err=%b rd=%h exp 1 00000000", er, rd);
        end
        xact(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h80ADBEEF}) begin
            errors++; $display("FAIL illegal_no_write got err=%b rd=%h exp 0 80adbeef", er, rd);
        end
        xact(0, 1'b0, 3'b110, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL ld_f3_110 got err=%b rd=%h exp 1 00000000", er, rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat;
        logic [32:0] exp_mis;
`ifdef R200_DMEM_MISALIGN_TRAP_EN
        exp_mis = {1'b1, 32'h0};
`else
        exp_mis = {1'b0, 32'h00001234};
`endif
        xact(0, 1'b1, 3'b001, 32'h22, 32'hABCD1234, rd, er, lat);
        xact(0, 1'b0, 3'b101, 32'h22, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h00001234}) begin
            errors++; $display("FAIL lhu_22 got err=%b rd=%h exp 0 00001234", er, rd);
        end
        xact(0, 1'b0, 3'b001, 32'h23, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== exp_mis) begin
            errors++; $display("FAIL lh_23_misalign got %b_%h exp %b_%h", er, rd, exp_mis[32], exp_mis[31:0]);
        end
        xact(0, 1'b1, 3'b001, 32'h20, 32'h00008001, rd, er, lat);
        xact(0, 1'b0, 3'b001, 32'h20, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'hFFFF8001}) begin
            errors++; $display("FAIL lh_20_neg got err=%b rd=%h exp 0 ffff8001", er, rd);
        end
        xact(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h12348001}) begin
            errors++; $display("FAIL lw_20 got err=%b rd=%h exp 0 12348001", er, rd);
        end
    endtask

    task automatic test_word_wrap();
        logic [31:0] rd; logic er; int lat;
        logic [32:0] exp_st, exp_ld;
`ifdef R200_DMEM_MISALIGN_TRAP_EN
        exp_st = {1'b1, 32'h0};
        exp_ld = {1'b0, 32'hA5A5A5A5};
`else
        exp_st = {1'b0, 32'h0};
        exp_ld = {1'b0, 32'h11223344};
`endif
        xact(0, 1'b1, 3'b010, 32'h30, 32'hA5A5A5A5, rd, er, lat);
        xact(0, 1'b1, 3'b010, 32'h31, 32'h11223344, rd, er, lat);
        checks++;
        if ({er, rd} !== exp_st) begin
            errors++; $display("FAIL sw_31_misalign got %b_%h exp %b_%h", er, rd, exp_st[32], exp_st[31:0]);
        end
        xact(0, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== exp_ld) begin
            errors++; $display("FAIL lw_30 got %b_%h exp %b_%h", er, rd, exp_ld[32], exp_ld[31:0]);
        end
        xact(0, 1'b0, 3'b010, 32'h1010, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd} !== {1'b0, 32'h80ADBEEF}) begin
            errors++; $display("FAIL lw_wrap_1010 got err=%b rd=%h exp 0 80adbeef", er, rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int n;
        xact(1, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, rd, er, lat);
        checks++;
        if ({er, rd, lat} !== {1'b0, 32'h0, 32'd4}) begin
            errors++; $display("FAIL w3_sw got err=%b rd=%h lat=%0d exp 0 0 4", er, rd, lat);
        end
        @(negedge clk);
        req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_func3[1] = 3'b010;
        req_addr[1] = 32'h10; req_wdata[1] = 32'h0;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready[1] !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ready got %b exp 0", req_ready[1]);
        end
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid[1], rsp_err[1], rsp_rdata[1]} !== 34'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got vld=%b err=%b rd=%h exp 0 0 0",
                     rsp_valid[1], rsp_err[1], rsp_rdata[1]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid[1] !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_rsp got vld=%b exp 0", rsp_valid[1]);
        end
        xact(1, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        checks++;
        if ({er, rd, lat} !== {1'b0, 32'hCAFEF00D, 32'd4}) begin
            errors++; $display("FAIL rst_mid_old_value got err=%b rd=%h lat=%0d exp 0 cafef00d 4", er, rd, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_func3[d] = 3'd0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
        end
        test_reset();
        test_roundtrip();
        test_byte();
        test_backpressure();
        test_illegal();
        test_half();
        test_word_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
